tcs_scan_sequencer: RTL and testbench

//  Sequencer for the TCS3200 colour sensor. Each scan frame does three steps:
//   - Selects the red, blue and green photodiode filters in turn (S2/S3).
//   - Waits a settle time after each filter change.
//   - Measures the high-pulse width of the sensor output, in clk_50M cycles.
//  All three periods are published together with a one-cycle valid strobe.

---
 rtl/tcs_scan_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_tcs_scan_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcs_scan_sequencer.sv
// TCS3200 colour sensor scan sequencer: steps red/blue/green filters, settles,
// measures one full high pulse per filter and publishes all three widths at once.
module tcs_scan_sequencer #(
    parameter int unsigned PW          = 15,
    parameter int unsigned SETTLE_CYC  = 50,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic          clk_50M,
    input  logic          rst_n,
    input  logic          start,
    input  logic          continuous,
    input  logic [1:0]    scale,
    input  logic          sensor_out,
    output logic          s0,
    output logic          s1,
    output logic          s2,
    output logic          s3,
    output logic          oe_n,
    output logic          busy,
    output logic [PW-1:0] r_per,
    output logic [PW-1:0] b_per,
    output logic [PW-1:0] g_per,
    output logic [2:0]    ch_timeout,
    output logic          frame_valid
);

    localparam int unsigned SETTLE_N = (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
    localparam int unsigned SW       = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
    localparam int unsigned TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_N - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd2;

    typedef enum logic [2:0] {
        IDLE, SETTLE, WAIT_LOW, WAIT_RISE, MEAS, NEXT, DONE
    } state_t;

    state_t state_q, state_n;

    logic sync_ff1, sync_q, sync_d;
    logic [SW-1:0] set_cnt_q, set_cnt_n;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_n;
    logic [PW-1:0] pulse_q, pulse_n;
    logic [1:0]    ch_q, ch_n;
    logic [2:0][PW-1:0] shadow_q, shadow_n;
    logic [2:0]    tmo_q, tmo_n;
    logic [1:0]    s01_n, s23_n;
    logic          oe_n_n, busy_n, fv_n;
    logic [PW-1:0] r_n, b_n, g_n;
    logic [2:0]    ch_timeout_n;

    logic rise, in_window, settle_done, timeout_hit;
    logic [1:0] scale_eff;

    assign rise        = sync_q & ~sync_d;
    assign in_window   = (state_q == WAIT_LOW) || (state_q == WAIT_RISE) || (state_q == MEAS);
    assign settle_done = (set_cnt_q == SETTLE_LAST);
    assign timeout_hit = in_window && (tmo_cnt_q == TMO_LAST);
    assign scale_eff   = (scale == 2'b00) ? 2'b01 : scale;

    // Filter select code {s2,s3} for a channel index: R=00, B=01, G=11
    function automatic logic [1:0] ch_code(input logic [1:0] ch);
        case (ch)
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous sensor pin, plus edge-detect delay
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b0;
            sync_q   <= 1'b0;
            sync_d   <= 1'b0;
        end else begin
            sync_ff1 <= sensor_out;
            sync_q   <= sync_ff1;
            sync_d   <= sync_q;
        end
    end

    // State register
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Next-state logic; a timeout wins over any edge seen in the same cycle
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:      if (start) state_n = SETTLE;
            SETTLE:    if (settle_done) state_n = WAIT_LOW;
            WAIT_LOW:  if (timeout_hit) state_n = NEXT;
                       else if (!sync_q) state_n = WAIT_RISE;
            WAIT_RISE: if (timeout_hit) state_n = NEXT;
                       else if (rise) state_n = MEAS;
            MEAS:      if (timeout_hit || !sync_q) state_n = NEXT;
            NEXT:      state_n = (ch_q == CH_G) ? DONE : SETTLE;
            DONE:      state_n = continuous ? SETTLE : IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Output / datapath next values for the registered outputs and counters
    always_comb begin
        ch_n         = ch_q;
        s01_n        = {s0, s1};
        s23_n        = {s2, s3};
        oe_n_n       = oe_n;
        busy_n       = busy;
        set_cnt_n    = set_cnt_q;
        tmo_cnt_n    = tmo_cnt_q;
        pulse_n      = pulse_q;
        shadow_n     = shadow_q;
        tmo_n        = tmo_q;
        r_n          = r_per;
        b_n          = b_per;
        g_n          = g_per;
        ch_timeout_n = ch_timeout;
        fv_n         = 1'b0;

        if (in_window && !timeout_hit) tmo_cnt_n = tmo_cnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    s01_n     = scale_eff;
                    oe_n_n    = 1'b0;
                    ch_n      = CH_R;
                    s23_n     = ch_code(CH_R);
                    busy_n    = 1'b1;
                    set_cnt_n = '0;
                end
            end
            SETTLE: begin
                if (settle_done) tmo_cnt_n = '0;
                else             set_cnt_n = set_cnt_q + SW'(1);
            end
            WAIT_RISE: begin
                if (timeout_hit) begin
                    shadow_n[ch_q] = '0;
                    tmo_n[ch_q]    = 1'b1;
                end else if (rise) begin
                    pulse_n = PW'(1);
                end
            end
            WAIT_LOW: begin
                if (timeout_hit) begin
                    shadow_n[ch_q] = '0;
                    tmo_n[ch_q]    = 1'b1;
                end
            end
            MEAS: begin
                if (timeout_hit) begin
                    shadow_n[ch_q] = '0;
                    tmo_n[ch_q]    = 1'b1;
                end else if (!sync_q) begin
                    shadow_n[ch_q] = pulse_q;
                end else if (pulse_q != '1) begin
                    pulse_n = pulse_q + PW'(1);
                end
            end
            NEXT: begin
                if (ch_q == CH_G) begin
                    r_n          = shadow_q[0];
                    b_n          = shadow_q[1];
                    g_n          = shadow_q[2];
                    ch_timeout_n = tmo_q;
                    fv_n         = 1'b1;
                    tmo_n        = '0;
                end else begin
                    ch_n      = ch_q + 2'd1;
                    s23_n     = ch_code(ch_q + 2'd1);
                    set_cnt_n = '0;
                end
            end
            DONE: begin
                ch_n  = CH_R;
                s23_n = ch_code(CH_R);
                if (continuous) begin
                    s01_n     = scale_eff;
                    set_cnt_n = '0;
                end else begin
                    s01_n  = 2'b00;
                    oe_n_n = 1'b1;
                    busy_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            set_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            pulse_q     <= '0;
            ch_q        <= CH_R;
            shadow_q    <= '0;
            tmo_q       <= '0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            oe_n        <= 1'b1;
            busy        <= 1'b0;
            r_per       <= '0;
            b_per       <= '0;
            g_per       <= '0;
            ch_timeout  <= '0;
            frame_valid <= 1'b0;
        end else begin
            set_cnt_q   <= set_cnt_n;
            tmo_cnt_q   <= tmo_cnt_n;
            pulse_q     <= pulse_n;
            ch_q        <= ch_n;
            shadow_q    <= shadow_n;
            tmo_q       <= tmo_n;
            s0          <= s01_n[1];
            s1          <= s01_n[0];
            s2          <= s23_n[1];
            s3          <= s23_n[0];
            oe_n        <= oe_n_n;
            busy        <= busy_n;
            r_per       <= r_n;
            b_per       <= b_n;
            g_per       <= g_n;
            ch_timeout  <= ch_timeout_n;
            frame_valid <= fv_n;
        end
    end

endmodule

// File: tb/tb_tcs_scan_sequencer.sv
// Bench for tcs_scan_sequencer: frame vectors from a table plus directed
// sequences for continuous mode, mid-frame reset and counter saturation.
`timescale 1ns/1ps
module tb_tcs_scan_sequencer;

    localparam int LO_W = 100;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // DUT A: PW=15, TIMEOUT_CYC=1000
    logic rst_n, start, continuous, sens_a;
    logic [1:0] scale;
    logic s0_a, s1_a, s2_a, s3_a, oe_n_a, busy_a, fv_a;
    logic [14:0] r_a, b_a, g_a;
    logic [2:0] tmo_a;

    // DUT B: PW=8 for saturation
    logic start_b, cont_b, sens_b;
    logic [1:0] scale_b;
    logic s0_b, s1_b, s2_b, s3_b, oe_n_b, busy_b, fv_b;
    logic [7:0] r_b, b_b, g_b;
    logic [2:0] tmo_b;

    tcs_scan_sequencer #(.PW(15), .SETTLE_CYC(50), .TIMEOUT_CYC(1000)) dut_a (
        .clk_50M(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .scale(scale), .sensor_out(sens_a), .s0(s0_a), .s1(s1_a), .s2(s2_a), .s3(s3_a),
        .oe_n(oe_n_a), .busy(busy_a), .r_per(r_a), .b_per(b_a), .g_per(g_a),
        .ch_timeout(tmo_a), .frame_valid(fv_a));

    tcs_scan_sequencer #(.PW(8), .SETTLE_CYC(50), .TIMEOUT_CYC(65535)) dut_b (
        .clk_50M(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b),
        .scale(scale_b), .sensor_out(sens_b), .s0(s0_b), .s1(s1_b), .s2(s2_b), .s3(s3_b),
        .oe_n(oe_n_b), .busy(busy_b), .r_per(r_b), .b_per(b_b), .g_per(g_b),
        .ch_timeout(tmo_b), .frame_valid(fv_b));

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int pick(input logic [1:0] code, input int wr, input int wb, input int wg);
        case (code)
            2'b01:   return wb;
            2'b11:   return wg;
            default: return wr;
        endcase
    endfunction

    // Sensor model A: each high pulse takes the width of the filter selected at its rise;
    // width 0 means the output is stuck low under that filter
    int wr_a = 100, wb_a = 200, wg_a = 300;
    logic model_a, man_en, man_val;
    assign sens_a = man_en ? man_val : model_a;

    initial begin : model_a_proc
        int cnt;
        int w;
        logic hi;
        model_a = 1'b0; cnt = 0; hi = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt > 0) cnt--;
            else if (hi) begin model_a = 1'b0; hi = 1'b0; cnt = LO_W - 1; end
            else begin
                w = pick({s2_a, s3_a}, wr_a, wb_a, wg_a);
                if (w == 0) model_a = 1'b0;
                else begin model_a = 1'b1; hi = 1'b1; cnt = w - 1; end
            end
        end
    end

    // Sensor model B: fixed widths R=300, B=200, G=100
    initial begin : model_b_proc
        int cnt;
        int w;
        logic hi;
        sens_b = 1'b0; cnt = 0; hi = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt > 0) cnt--;
            else if (hi) begin sens_b = 1'b0; hi = 1'b0; cnt = LO_W - 1; end
            else begin
                w = pick({s2_b, s3_b}, 300, 200, 100);
                sens_b = 1'b1; hi = 1'b1; cnt = w - 1;
            end
        end
    end

    task automatic wait_fv_a(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (fv_a) begin got = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start_a();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0] scale;
        int wr, wb, wg;
        int er, eb, eg;
        logic [2:0] etmo;
        logic [1:0] es01;
    } vec_t;

    vec_t vecs [4];

    initial begin : main
        bit got;
        bit flag;
        int nfv;
        logic [1:0] last;
        logic [1:0] seq [$];
        logic [1:0] exp_seq [4];

        vecs[0] = '{scale: 2'b01, wr: 100, wb: 200, wg: 300, er: 100, eb: 200, eg: 300, etmo: 3'b000, es01: 2'b01};
        vecs[1] = '{scale: 2'b00, wr: 50,  wb: 60,  wg: 70,  er: 50,  eb: 60,  eg: 70,  etmo: 3'b000, es01: 2'b01};
        vecs[2] = '{scale: 2'b10, wr: 100, wb: 0,   wg: 300, er: 100, eb: 0,   eg: 300, etmo: 3'b010, es01: 2'b10};
        vecs[3] = '{scale: 2'b11, wr: 1,   wb: 2,   wg: 3,   er: 1,   eb: 2,   eg: 3,   etmo: 3'b000, es01: 2'b11};
        exp_seq[0] = 2'b00; exp_seq[1] = 2'b01; exp_seq[2] = 2'b11; exp_seq[3] = 2'b00;

        // Reset with arbitrary inputs
        rst_n = 1'b0; start = 1'b1; continuous = 1'b1; scale = 2'b11;
        man_en = 1'b1; man_val = 1'b1;
        start_b = 1'b0; cont_b = 1'b0; scale_b = 2'b01;
        repeat (5) @(negedge clk);
        chk("rst s0s1s2s3", {s0_a, s1_a, s2_a, s3_a}, 0);
        chk("rst oe_n", oe_n_a, 1);
        chk("rst busy", busy_a, 0);
        chk("rst frame_valid", fv_a, 0);
        chk("rst pers", {r_a, b_a, g_a}, 0);
        chk("rst ch_timeout", tmo_a, 0);
        start = 1'b0; continuous = 1'b0; man_en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven single frames
        for (int v = 0; v < 4; v++) begin
            scale = vecs[v].scale;
            wr_a = vecs[v].wr; wb_a = vecs[v].wb; wg_a = vecs[v].wg;
            pulse_start_a();
            chk($sformatf("v%0d busy on start", v), busy_a, 1);
            chk($sformatf("v%0d s0s1 latched", v), {s0_a, s1_a}, vecs[v].es01);
            chk($sformatf("v%0d oe_n on", v), oe_n_a, 0);
            chk($sformatf("v%0d s2s3 red", v), {s2_a, s3_a}, 0);
            scale = vecs[v].scale ^ 2'b11;
            wait_fv_a(got);
            chk($sformatf("v%0d frame_valid seen", v), got, 1);
            chk($sformatf("v%0d r_per", v), r_a, vecs[v].er);
            chk($sformatf("v%0d b_per", v), b_a, vecs[v].eb);
            chk($sformatf("v%0d g_per", v), g_a, vecs[v].eg);
            chk($sformatf("v%0d ch_timeout", v), tmo_a, vecs[v].etmo);
            chk($sformatf("v%0d s0s1 held", v), {s0_a, s1_a}, vecs[v].es01);
            @(negedge clk);
            chk($sformatf("v%0d fv one cycle", v), fv_a, 0);
            chk($sformatf("v%0d busy after", v), busy_a, 0);
            chk($sformatf("v%0d s0s1 idle", v), {s0_a, s1_a}, 0);
            chk($sformatf("v%0d oe_n idle", v), oe_n_a, 1);
            repeat (5) @(negedge clk);
        end

        // Continuous mode: back-to-back frames, filter sequence
        scale = 2'b01; wr_a = 20; wb_a = 30; wg_a = 40; continuous = 1'b1;
        pulse_start_a();
        seq.delete();
        last = {s2_a, s3_a};
        seq.push_back(last);
        nfv = 0; flag = 1'b0;
        for (int i = 0; i < 12000 && nfv < 2; i++) begin
            @(negedge clk);
            if (!busy_a) flag = 1'b1;
            if ({s2_a, s3_a} != last) begin last = {s2_a, s3_a}; seq.push_back(last); end
            if (fv_a) nfv++;
        end
        chk("t5 two frames", nfv, 2);
        chk("t5 busy stays high", flag, 0);
        chk("t5 r_per", r_a, 20);
        chk("t5 g_per", g_a, 40);
        chk("t5 seq length ok", (seq.size() >= 4) ? 1 : 0, 1);
        for (int k = 0; k < 4; k++)
            if (k < seq.size()) chk($sformatf("t5 s2s3 step%0d", k), seq[k], exp_seq[k]);

        // Drop continuous during blue of the third frame; start while busy is ignored
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ({s2_a, s3_a} == 2'b01) begin got = 1'b1; break; end
        end
        chk("t5 blue reached", got, 1);
        continuous = 1'b0;
        pulse_start_a();
        wait_fv_a(got);
        chk("t5 last frame valid", got, 1);
        chk("t5 last b_per", b_a, 30);
        @(negedge clk);
        chk("t5 idle after", busy_a, 0);
        flag = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (busy_a || fv_a) flag = 1'b1;
        end
        chk("t5 start not queued", flag, 0);

        // Reset during MEAS on green
        scale = 2'b10; wr_a = 100; wb_a = 200; wg_a = 300;
        pulse_start_a();
        got = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ({s2_a, s3_a} == 2'b11) begin got = 1'b1; break; end
        end
        chk("t6 green reached", got, 1);
        man_val = 1'b0; man_en = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (fv_a) flag = 1'b1; end
        man_val = 1'b1;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (fv_a) flag = 1'b1; end
        chk("t6 prev r_per held", r_a, 20);
        chk("t6 busy before rst", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("t6 rst s0s1s2s3", {s0_a, s1_a, s2_a, s3_a}, 0);
        chk("t6 rst oe_n", oe_n_a, 1);
        chk("t6 rst busy", busy_a, 0);
        chk("t6 rst pers", {r_a, b_a, g_a}, 0);
        chk("t6 rst ch_timeout", tmo_a, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1; man_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fv_a || busy_a) flag = 1'b1;
        end
        chk("t6 no frame_valid", flag, 0);
        chk("t6 g_per not partial", g_a, 0);

        // Saturation with PW=8
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (fv_b) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("t4 frame_valid seen", got, 1);
        chk("t4 r_per saturated", r_b, 255);
        chk("t4 b_per", b_b, 200);
        chk("t4 g_per", g_b, 100);
        chk("t4 ch_timeout", tmo_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
